// File: rtl/serv_bus_pkg.sv
// Shared encodings and types for the SERV ibus/dbus arbiter onto one Wishbone master.
package serv_bus_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam logic [7:0] TIMEOUT_DEF = 8'd255;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

endpackage

// File: rtl/serv_bus_wdog.sv
// Grant watchdog: counts stalled grant cycles and flags when the limit is reached.
module serv_bus_wdog (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] cnt_q, cnt_d;

  // Holds at the limit so a missed consumer never sees the counter wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != limit)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == limit);

endmodule

// File: rtl/serv_bus_sched.sv
// Round-robin arbiter of SERV ibus/dbus onto a single Wishbone master port.
// Optional grant timeout enabled by defining SERV_BUS_TIMEOUT_EN.
module serv_bus_sched
  import serv_bus_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout
);

  logic [1:0] state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       wb_cyc_q, wb_cyc_d;

  logic    gnt_i, gnt_d, in_gnt, owner_cyc;
  logic    wb_ack, tmo, done;
  wb_req_t wb;

  assign gnt_i     = (state_q == GNT_I);
  assign gnt_d     = (state_q == GNT_D);
  assign in_gnt    = gnt_i | gnt_d;
  assign owner_cyc = (gnt_i & i_ibus_cyc) | (gnt_d & i_dbus_cyc);

  // A reset cycle swallows any slave ack so an aborted transfer never completes.
  assign wb_ack = in_gnt & i_wb_ack & ~i_rst;

`ifdef SERV_BUS_TIMEOUT_EN
  logic wd_expired;

  serv_bus_wdog u_wdog (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     (~in_gnt),
    .en      (in_gnt & ~i_wb_ack),
    .limit   (TIMEOUT),
    .expired (wd_expired)
  );

  // A real ack on the expiry cycle wins over the synthetic one.
  assign tmo = in_gnt & owner_cyc & wd_expired & ~i_wb_ack & ~i_rst;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif

  assign done = wb_ack | tmo;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (i_ibus_cyc && i_dbus_cyc)
          state_d = last_d_q ? GNT_I : GNT_D;
        else if (i_ibus_cyc)
          state_d = GNT_I;
        else if (i_dbus_cyc)
          state_d = GNT_D;
      end
      GNT_I: begin
        if (done) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end else if (!i_ibus_cyc) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        if (done) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end else if (!i_dbus_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wb_cyc_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wb_cyc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wb_cyc_q <= wb_cyc_d;
    end
  end

  always_comb begin
    wb = '0;
    if (gnt_i) begin
      wb.adr = i_ibus_adr;
      wb.sel = 4'hf;
    end else if (gnt_d) begin
      wb.adr = i_dbus_adr;
      wb.dat = i_dbus_dat;
      wb.sel = i_dbus_sel;
      wb.we  = i_dbus_we;
    end
  end

  assign o_wb_adr = wb.adr;
  assign o_wb_dat = wb.dat;
  assign o_wb_sel = wb.sel;
  assign o_wb_we  = wb.we;
  assign o_wb_cyc = wb_cyc_q;

  assign o_ibus_ack = gnt_i & done;
  assign o_dbus_ack = gnt_d & done;
  assign o_ibus_rdt = (gnt_i & wb_ack) ? i_wb_rdt : 32'd0;
  assign o_dbus_rdt = (gnt_d & wb_ack) ? i_wb_rdt : 32'd0;
  assign o_timeout  = tmo;

endmodule

// File: tb/tb_serv_bus_sched.sv
// Directed bench for serv_bus_sched: stimulus pushes expected acks, a monitor pops and compares.
module tb_serv_bus_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr, dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we, dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        timeout;

  typedef struct {
    bit          is_d;
    logic [31:0] rdt;
    bit          tmo;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;

  serv_bus_sched #(.TIMEOUT(8'd4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ibus_adr (ibus_adr),
    .i_ibus_cyc (ibus_cyc),
    .o_ibus_rdt (ibus_rdt),
    .o_ibus_ack (ibus_ack),
    .i_dbus_adr (dbus_adr),
    .i_dbus_dat (dbus_dat),
    .i_dbus_sel (dbus_sel),
    .i_dbus_we  (dbus_we),
    .i_dbus_cyc (dbus_cyc),
    .o_dbus_rdt (dbus_rdt),
    .o_dbus_ack (dbus_ack),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .o_timeout  (timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input bit is_d, input logic [31:0] rdt, input bit tmo);
    exp_t e;
    e.is_d = is_d;
    e.rdt  = rdt;
    e.tmo  = tmo;
    sb.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every requester ack.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("ack_exclusive", 32'(ibus_ack & dbus_ack), 32'd0);
      if (!ibus_ack) chk("ibus_rdt_zero", ibus_rdt, 32'd0);
      if (!dbus_ack) chk("dbus_rdt_zero", dbus_rdt, 32'd0);
      if (ibus_ack || dbus_ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack ibus=%0b dbus=%0b expected=none", ibus_ack, dbus_ack);
        end else begin
          e = sb.pop_front();
          chk("ack_bus_is_d", 32'(dbus_ack), 32'(e.is_d));
          chk("ack_rdt", dbus_ack ? dbus_rdt : ibus_rdt, e.rdt);
          chk("ack_timeout", 32'(timeout), 32'(e.tmo));
        end
      end else begin
        chk("timeout_without_ack", 32'(timeout), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    wb_rdt = '0; wb_ack = 1'b0;
    nxt(); nxt();

    // reset state
    rst = 1'b0; mon_en = 1'b1;
    mid();
    chk("rst_wb_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_wb_adr", wb_adr, 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    nxt();

    // single ibus read, ack on cycle 3
    ibus_cyc = 1'b1; ibus_adr = 32'h100;
    mid(); chk("ib_c1_cyc", 32'(wb_cyc), 32'd0); nxt();
    mid();
    chk("ib_c2_cyc", 32'(wb_cyc), 32'd1);
    chk("ib_c2_adr", wb_adr, 32'h100);
    chk("ib_c2_sel", 32'(wb_sel), 32'hf);
    chk("ib_c2_we", 32'(wb_we), 32'd0);
    chk("ib_c2_dat", wb_dat, 32'd0);
    nxt();
    wb_ack = 1'b1; wb_rdt = 32'hDEADBEEF; push(1'b0, 32'hDEADBEEF, 1'b0);
    mid(); chk("ib_c3_cyc", 32'(wb_cyc), 32'd1); chk("ib_c3_ack", 32'(ibus_ack), 32'd1); nxt();
    wb_ack = 1'b0; wb_rdt = '0; ibus_cyc = 1'b0;
    mid(); chk("ib_c4_cyc", 32'(wb_cyc), 32'd0); nxt();

    // tie: dbus first, then ibus while dbus keeps requesting
    ibus_cyc = 1'b1; ibus_adr = 32'h300;
    dbus_cyc = 1'b1; dbus_adr = 32'h400; dbus_sel = 4'hf; dbus_we = 1'b0;
    mid(); nxt();
    mid(); chk("tie_dbus_first", wb_adr, 32'h400); nxt();
    wb_ack = 1'b1; wb_rdt = 32'hD0D00001; push(1'b1, 32'hD0D00001, 1'b0);
    mid(); chk("tie_dbus_ack", 32'(dbus_ack), 32'd1); nxt();
    wb_ack = 1'b0; wb_rdt = '0;
    mid(); chk("tie_gap_cyc", 32'(wb_cyc), 32'd0); nxt();
    mid(); chk("rr_ibus_next", wb_adr, 32'h300); nxt();
    wb_ack = 1'b1; wb_rdt = 32'h11110002; push(1'b0, 32'h11110002, 1'b0);
    mid(); nxt();
    wb_ack = 1'b0; wb_rdt = '0; ibus_cyc = 1'b0;
    mid(); nxt();

    // dbus owner drops cyc in its 2nd grant cycle
    mid(); chk("drop_g1_adr", wb_adr, 32'h400); chk("drop_g1_cyc", 32'(wb_cyc), 32'd1); nxt();
    dbus_cyc = 1'b0;
    mid(); chk("drop_g2_cyc", 32'(wb_cyc), 32'd1); chk("drop_g2_ack", 32'(dbus_ack), 32'd0); nxt();
    mid(); chk("drop_idle_cyc", 32'(wb_cyc), 32'd0); nxt();

    // tie again: last_d untouched by the drop, so dbus wins; write fields pass through
    ibus_cyc = 1'b1; ibus_adr = 32'h500;
    dbus_cyc = 1'b1; dbus_adr = 32'h2000; dbus_dat = 32'h12345678; dbus_sel = 4'b0011; dbus_we = 1'b1;
    mid(); nxt();
    mid();
    chk("wr_adr", wb_adr, 32'h2000);
    chk("wr_dat", wb_dat, 32'h12345678);
    chk("wr_sel", 32'(wb_sel), 32'h3);
    chk("wr_we", 32'(wb_we), 32'd1);
    nxt();
    wb_ack = 1'b1; wb_rdt = 32'hAAAA5555; push(1'b1, 32'hAAAA5555, 1'b0);
    mid(); nxt();
    wb_ack = 1'b0; wb_rdt = '0; dbus_cyc = 1'b0; dbus_we = 1'b0;
    mid(); chk("wr_cyc_drop", 32'(wb_cyc), 32'd0); nxt();

    // reset mid-grant with a coincident ack, then a stray ack in IDLE
    mid(); chk("rg_grant_adr", wb_adr, 32'h500); nxt();
    rst = 1'b1; wb_ack = 1'b1; wb_rdt = 32'hBAD0BAD0; ibus_cyc = 1'b0;
    mid(); chk("rg_no_ack", 32'(ibus_ack), 32'd0); nxt();
    rst = 1'b0;
    mid();
    chk("rg_cyc", 32'(wb_cyc), 32'd0);
    chk("rg_adr", wb_adr, 32'd0);
    chk("rg_dat", wb_dat, 32'd0);
    chk("rg_sel", 32'(wb_sel), 32'd0);
    chk("rg_we", 32'(wb_we), 32'd0);
    chk("stray_ibus_ack", 32'(ibus_ack), 32'd0);
    chk("stray_dbus_ack", 32'(dbus_ack), 32'd0);
    chk("rg_timeout", 32'(timeout), 32'd0);
    nxt();
    wb_ack = 1'b0; wb_rdt = '0;
    mid(); chk("stray_after_cyc", 32'(wb_cyc), 32'd0); nxt();

`ifdef SERV_BUS_TIMEOUT_EN
    // no slave ack: synthetic ack 4 cycles after grant entry
    ibus_cyc = 1'b1; ibus_adr = 32'h600;
    mid(); nxt();
    for (int g = 0; g < 4; g++) begin
      mid(); chk("tmo_wait_ack", 32'(ibus_ack), 32'd0); chk("tmo_wait_cyc", 32'(wb_cyc), 32'd1); nxt();
    end
    push(1'b0, 32'd0, 1'b1);
    mid(); chk("tmo_ack", 32'(ibus_ack), 32'd1); chk("tmo_pulse", 32'(timeout), 32'd1); nxt();
    ibus_cyc = 1'b0;
    mid(); chk("tmo_idle_cyc", 32'(wb_cyc), 32'd0); nxt();

    // real ack on the expiry cycle wins
    ibus_cyc = 1'b1; ibus_adr = 32'h700;
    mid(); nxt();
    for (int g = 0; g < 4; g++) begin
      mid(); chk("race_wait_ack", 32'(ibus_ack), 32'd0); nxt();
    end
    wb_ack = 1'b1; wb_rdt = 32'hCAFEF00D; push(1'b0, 32'hCAFEF00D, 1'b0);
    mid(); chk("race_no_pulse", 32'(timeout), 32'd0); nxt();
    wb_ack = 1'b0; wb_rdt = '0; ibus_cyc = 1'b0;
    mid(); chk("race_idle_cyc", 32'(wb_cyc), 32'd0); nxt();
`else
    // without the watchdog a grant waits indefinitely
    ibus_cyc = 1'b1; ibus_adr = 32'h600;
    mid(); nxt();
    for (int g = 0; g < 10; g++) begin
      mid();
      chk("hold_cyc", 32'(wb_cyc), 32'd1);
      chk("hold_ack", 32'(ibus_ack), 32'd0);
      chk("hold_timeout", 32'(timeout), 32'd0);
      nxt();
    end
    wb_ack = 1'b1; wb_rdt = 32'h600D600D; push(1'b0, 32'h600D600D, 1'b0);
    mid(); chk("hold_final_ack", 32'(ibus_ack), 32'd1); nxt();
    wb_ack = 1'b0; wb_rdt = '0; ibus_cyc = 1'b0;
    mid(); chk("hold_idle_cyc", 32'(wb_cyc), 32'd0); nxt();
`endif

    mid();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
